// File: rtl/nes_joypad_port.sv
// ---------------------------------------------------------------------------
// nes_joypad_port
//
// CPU-bus responder for the NES controller registers $4016/$4017. It decodes
// CPU accesses, returns the serial bit of each controller port on reads,
// drives the shared parallel-load strobe (pad_latch) and a per-port serial
// clock, and samples the per-port serial data through 2-FF synchronisers.
//
// Parameters:
//   CLK_PULSE    length of each pad_clk low pulse in clk_ph2 cycles (1..255)
//   OPEN_BUS_HI  value returned on Data_bus_out[7:5] for controller reads
//
// Ports:
//   clk_ph2       system clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   bus_en        one-cycle qualifier for Addr_bus / R_nW / Data_bus_in
//   Addr_bus      CPU address
//   Data_bus_in   CPU write data (only bit 0 matters, for $4016)
//   R_nW          1 = read, 0 = write
//   Data_bus_out  read data, valid the cycle after a controller read
//   rd_hit        high for one cycle when Data_bus_out carries read data
//   pad_latch     controller parallel-load strobe, active high
//   pad_clk       per-port serial clock, idle high, pulses low
//                 (bit 0 = $4016, bit 1 = $4017)
//   pad_data      per-port serial data, active low, asynchronous
//
// Optional build macro JOYPAD_DBG_EN adds pad0_dbg / pad1_dbg (history of the
// last eight bits returned per port, newest in bit 0) and rd_cnt0_dbg /
// rd_cnt1_dbg (reads per port mod 8, cleared by writing strobe = 1).
// ---------------------------------------------------------------------------
module nes_joypad_port #(
  parameter int         CLK_PULSE   = 4,
  parameter logic [2:0] OPEN_BUS_HI = 3'b010
) (
  input  logic        clk_ph2,
  input  logic        rst,
  input  logic        bus_en,
  input  logic [15:0] Addr_bus,
  input  logic [7:0]  Data_bus_in,
  input  logic        R_nW,
  output logic [7:0]  Data_bus_out,
  output logic        rd_hit,
  output logic        pad_latch,
  output logic [1:0]  pad_clk,
  input  logic [1:0]  pad_data
`ifdef JOYPAD_DBG_EN
  ,
  output logic [7:0]  pad0_dbg,
  output logic [7:0]  pad1_dbg,
  output logic [2:0]  rd_cnt0_dbg,
  output logic [2:0]  rd_cnt1_dbg
`endif
);

  // Counter only has to hold CLK_PULSE, so it can never wrap.
  localparam int            CW         = $clog2(CLK_PULSE + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(CLK_PULSE);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pstate_t;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [1:0] hit;
  logic [1:0] rd_req;
  logic       wr_4016;
  logic       strobe_set;

  assign hit[0]     = (Addr_bus == 16'h4016);
  assign hit[1]     = (Addr_bus == 16'h4017);
  assign rd_req     = {2{bus_en & R_nW}} & hit;
  assign wr_4016    = bus_en & ~R_nW & hit[0];
  assign strobe_set = wr_4016 & Data_bus_in[0];

  // Only the strobe bit of a $4016 write is meaningful.
  logic unused_wr_bits;
  assign unused_wr_bits = ^Data_bus_in[7:1];

  // -------------------------------------------------------------------------
  // pad_data synchronisers (reset to the "not pressed" level)
  // -------------------------------------------------------------------------
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;

  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
    end else begin
      sync1_reg <= pad_data;
      sync2_reg <= sync1_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Strobe register; pad_latch is driven straight from it
  // -------------------------------------------------------------------------
  logic strobe_reg;

  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      strobe_reg <= 1'b0;
    end else if (wr_4016) begin
      strobe_reg <= Data_bus_in[0];
    end
  end

  assign pad_latch = strobe_reg;

  // -------------------------------------------------------------------------
  // Read response: one cycle latency. The bit is taken from the synchroniser
  // in the read cycle itself, i.e. before the pulse this read starts can
  // shift the pad.
  // -------------------------------------------------------------------------
  logic [7:0] data_out_reg;
  logic       rd_hit_reg;

  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      data_out_reg <= 8'h00;
      rd_hit_reg   <= 1'b0;
    end else begin
      rd_hit_reg <= |rd_req;
      if (rd_req[0]) begin
        data_out_reg <= {OPEN_BUS_HI, 4'b0000, ~sync2_reg[0]};
      end else if (rd_req[1]) begin
        data_out_reg <= {OPEN_BUS_HI, 4'b0000, ~sync2_reg[1]};
      end else begin
        data_out_reg <= 8'h00;
      end
    end
  end

  assign Data_bus_out = data_out_reg;
  assign rd_hit       = rd_hit_reg;

  // -------------------------------------------------------------------------
  // Per-port serial clock FSM
  // -------------------------------------------------------------------------
`ifdef JOYPAD_DBG_EN
  logic [7:0] pad_dbg_reg [2];
  logic [2:0] rd_cnt_reg  [2];
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      pstate_t       state_reg;
      pstate_t       state_next;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          clk_level;

      always_ff @(posedge clk_ph2 or posedge rst) begin
        if (rst) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          ST_IDLE: begin
            // While strobe is high the pad is in parallel load: no clock.
            if (rd_req[gi] && !strobe_reg) begin
              state_next = ST_PULSE;
              cnt_next   = PULSE_LOAD;
            end
          end
          ST_PULSE: begin
            if (strobe_set) begin
              // Re-entering parallel load cancels the shift.
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else if (rd_req[gi]) begin
              // Stretch the same low phase; no extra edge reaches the pad.
              cnt_next = PULSE_LOAD;
            end else if (cnt_reg <= CW'(1)) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg - CW'(1);
            end
          end
          default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      always_comb begin
        clk_level = (state_reg == ST_IDLE);
      end

      assign pad_clk[gi] = clk_level;

`ifdef JOYPAD_DBG_EN
      always_ff @(posedge clk_ph2 or posedge rst) begin
        if (rst) begin
          pad_dbg_reg[gi] <= 8'h00;
          rd_cnt_reg[gi]  <= 3'd0;
        end else begin
          if (rd_req[gi]) begin
            pad_dbg_reg[gi] <= {pad_dbg_reg[gi][6:0], ~sync2_reg[gi]};
          end
          if (strobe_set) begin
            rd_cnt_reg[gi] <= 3'd0;
          end else if (rd_req[gi]) begin
            rd_cnt_reg[gi] <= rd_cnt_reg[gi] + 3'd1;
          end
        end
      end
`endif
    end
  endgenerate

`ifdef JOYPAD_DBG_EN
  assign pad0_dbg    = pad_dbg_reg[0];
  assign pad1_dbg    = pad_dbg_reg[1];
  assign rd_cnt0_dbg = rd_cnt_reg[0];
  assign rd_cnt1_dbg = rd_cnt_reg[1];
`endif

endmodule

// File: tb/tb_nes_joypad_port.sv
`timescale 1ns/1ps
module tb_nes_joypad_port;

  logic        clk_ph2;
  logic        rst;
  logic        bus_en;
  logic [15:0] Addr_bus;
  logic [7:0]  Data_bus_in;
  logic        R_nW;
  logic [7:0]  Data_bus_out;
  logic        rd_hit;
  logic        pad_latch;
  logic [1:0]  pad_clk;
  logic [1:0]  pad_data;

  // Pad stimulus: manual levels, or a shift-register controller on port 1
  logic [1:0]  man_data;
  logic        model_mode;
  logic [7:0]  buttons;
  logic [7:0]  sh;

  int          checks;
  int          failures;
  logic [7:0]  exp_q [$];

  int          pulses0;
  int          pulses1;
  time         fall0;
  time         rise0;
  int          base0;
  int          base1;

  // Hand-derived bit sequence for buttons 8'hA5 sent bit 0 first
  int          seq4 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  nes_joypad_port dut (
    .clk_ph2      (clk_ph2),
    .rst          (rst),
    .bus_en       (bus_en),
    .Addr_bus     (Addr_bus),
    .Data_bus_in  (Data_bus_in),
    .R_nW         (R_nW),
    .Data_bus_out (Data_bus_out),
    .rd_hit       (rd_hit),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .pad_data     (pad_data)
  );

  initial clk_ph2 = 1'b0;
  always #5 clk_ph2 = ~clk_ph2;

  assign pad_data = model_mode ? {~sh[0], man_data[0]} : man_data;

  // Controller model for port 1: parallel load while latched, shift on the
  // rising edge of its serial clock (1s fill in after eight bits).
  initial begin
    sh = 8'hFF;
    forever begin
      @(posedge pad_latch or posedge pad_clk[1]);
      if (pad_latch) sh = buttons;
      else           sh = {1'b1, sh[7:1]};
    end
  end

  initial begin
    pulses0 = 0;
    fall0   = 0;
    forever begin
      @(negedge pad_clk[0]);
      pulses0++;
      fall0 = $time;
    end
  end

  initial begin
    rise0 = 0;
    forever begin
      @(posedge pad_clk[0]);
      rise0 = $time;
    end
  end

  initial begin
    pulses1 = 0;
    forever begin
      @(negedge pad_clk[1]);
      pulses1++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic access(input logic [15:0] a, input logic rnw, input logic [7:0] d, input logic en);
    @(posedge clk_ph2);
    #1;
    bus_en      = en;
    Addr_bus    = a;
    R_nW        = rnw;
    Data_bus_in = d;
    @(posedge clk_ph2);
    #1;
    bus_en      = 1'b0;
    Addr_bus    = 16'h0000;
    R_nW        = 1'b1;
    Data_bus_in = 8'h00;
    $display("bus %s addr=%04h wdata=%02h en=%0b -> rd_hit=%0b dout=%02h latch=%0b pad_clk=%02b",
             rnw ? "RD" : "WR", a, d, en, rd_hit, Data_bus_out, pad_latch, pad_clk);
  endtask

  // Scoreboard monitor: every rd_hit consumes one expected read value; all
  // other cycles must show an idle data bus.
  initial begin
    forever begin
      @(negedge clk_ph2);
      if (!rst) begin
        if (rd_hit) begin
          if (exp_q.size() == 0) chk("sb_unexpected_rd_hit", rd_hit, 1'b0);
          else                   chk("sb_read_data", Data_bus_out, exp_q.pop_front());
        end else begin
          chk("idle_data_out", Data_bus_out, 8'h00);
        end
      end
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus_en      = 1'b0;
    Addr_bus    = 16'h0000;
    Data_bus_in = 8'h00;
    R_nW        = 1'b1;
    man_data    = 2'b11;
    model_mode  = 1'b0;
    buttons     = 8'hA5;

    // Power-on reset values
    repeat (3) @(posedge clk_ph2);
    #1;
    chk("rst_pad_clk", pad_clk, 2'b11);
    chk("rst_dout", Data_bus_out, 8'h00);
    chk("rst_rd_hit", rd_hit, 1'b0);
    chk("rst_latch", pad_latch, 1'b0);
    @(negedge clk_ph2);
    rst = 1'b0;

    // Strobe writes and the ignored $4017 write
    access(16'h4016, 1'b0, 8'h01, 1'b1);
    chk("latch_set", pad_latch, 1'b1);
    access(16'h4016, 1'b0, 8'h00, 1'b1);
    chk("latch_clr", pad_latch, 1'b0);
    access(16'h4017, 1'b0, 8'hFF, 1'b1);
    chk("wr4017_latch", pad_latch, 1'b0);
    chk("wr4017_pad_clk", pad_clk, 2'b11);
    chk("wr4017_rd_hit", rd_hit, 1'b0);

    // Single read of port 0 with A pressed
    man_data = 2'b10;
    repeat (3) @(posedge clk_ph2);
    base0 = pulses0;
    base1 = pulses1;
    exp_q.push_back(8'h41);
    access(16'h4016, 1'b1, 8'h00, 1'b1);
    chk("read_pad_clk0_low", pad_clk[0], 1'b0);
    repeat (10) @(posedge clk_ph2);
    chk("pulse0_len", 32'((rise0 - fall0) / 10), 4);
    chk("pulse0_count", pulses0 - base0, 1);
    chk("pulse1_none", pulses1 - base1, 0);

    // Re-read during the pulse stretches it without an extra edge
    base0 = pulses0;
    exp_q.push_back(8'h41);
    access(16'h4016, 1'b1, 8'h00, 1'b1);
    exp_q.push_back(8'h41);
    access(16'h4016, 1'b1, 8'h00, 1'b1);
    repeat (10) @(posedge clk_ph2);
    chk("reread_len", 32'((rise0 - fall0) / 10), 6);
    chk("reread_count", pulses0 - base0, 1);

    // Serial read-out of 8'hA5 on port 1
    model_mode = 1'b1;
    man_data   = 2'b11;
    access(16'h4016, 1'b0, 8'h01, 1'b1);
    access(16'h4016, 1'b0, 8'h00, 1'b1);
    repeat (3) @(posedge clk_ph2);
    base0 = pulses0;
    base1 = pulses1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({3'b010, 4'b0000, seq4[i][0]});
      access(16'h4017, 1'b1, 8'h00, 1'b1);
      repeat (11) @(posedge clk_ph2);
    end
    chk("serial_pulses1", pulses1 - base1, 8);
    chk("serial_pulses0", pulses0 - base0, 0);

    // Reads while strobe is high: no clock, A returned each time
    model_mode = 1'b0;
    man_data   = 2'b10;
    access(16'h4016, 1'b0, 8'h01, 1'b1);
    repeat (3) @(posedge clk_ph2);
    base0 = pulses0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h41);
      access(16'h4016, 1'b1, 8'h00, 1'b1);
      chk("strobe_read_pad_clk", pad_clk, 2'b11);
      repeat (2) @(posedge clk_ph2);
    end
    chk("strobe_read_no_pulse", pulses0 - base0, 0);

    // Strobe = 1 written during an active pulse aborts it
    access(16'h4016, 1'b0, 8'h00, 1'b1);
    repeat (2) @(posedge clk_ph2);
    base0 = pulses0;
    exp_q.push_back(8'h41);
    access(16'h4016, 1'b1, 8'h00, 1'b1);
    @(posedge clk_ph2);
    #1;
    chk("abort_pulse_active", pad_clk[0], 1'b0);
    access(16'h4016, 1'b0, 8'h01, 1'b1);
    chk("abort_pad_clk", pad_clk, 2'b11);
    repeat (8) @(posedge clk_ph2);
    chk("abort_no_extra_edge", pulses0 - base0, 1);
    access(16'h4016, 1'b0, 8'h00, 1'b1);

    // Non-matching accesses
    repeat (3) @(posedge clk_ph2);
    base0 = pulses0;
    base1 = pulses1;
    access(16'h4015, 1'b1, 8'h00, 1'b1);
    chk("miss4015_rd_hit", rd_hit, 1'b0);
    chk("miss4015_dout", Data_bus_out, 8'h00);
    access(16'h4018, 1'b1, 8'h00, 1'b1);
    chk("miss4018_rd_hit", rd_hit, 1'b0);
    access(16'h4016, 1'b1, 8'h00, 1'b0);
    chk("no_en_rd_hit", rd_hit, 1'b0);
    repeat (6) @(posedge clk_ph2);
    chk("miss_pulses0", pulses0 - base0, 0);
    chk("miss_pulses1", pulses1 - base1, 0);

    // Asynchronous reset in the middle of a pulse
    access(16'h4016, 1'b1, 8'h00, 1'b1);
    chk("pre_rst_rd_hit", rd_hit, 1'b1);
    chk("pre_rst_pad_clk0", pad_clk[0], 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pad_clk", pad_clk, 2'b11);
    chk("midrst_dout", Data_bus_out, 8'h00);
    chk("midrst_rd_hit", rd_hit, 1'b0);
    chk("midrst_latch", pad_latch, 1'b0);
    repeat (2) @(posedge clk_ph2);
    @(negedge clk_ph2);
    rst   = 1'b0;
    base0 = pulses0;
    repeat (10) @(posedge clk_ph2);
    #1;
    chk("post_rst_pad_clk", pad_clk, 2'b11);
    chk("post_rst_no_glitch", pulses0 - base0, 0);

    repeat (3) @(posedge clk_ph2);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nes_joypad_port.md
Name: nes_joypad_port

Overview:
- CPU-bus responder for the NES controller registers $4016/$4017.
- Serves the CPU's read/write accesses on the address/data/R_nW interface.
- Drives the serial controller-port signals (latch, per-port clock) and samples the per-port serial data.
- Sits beside the CPU on the system bus; the bus mux selects Data_bus_out when rd_hit is high.

Parameters:
- CLK_PULSE, 4, length of the pad_clk low pulse in clk_ph2 cycles after each read; legal range 1..255.
- OPEN_BUS_HI, 3'b010, value returned on Data_bus_out[7:5] for controller reads (upper address byte open-bus image).

Ports:
- clk_ph2  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_en  in  1  one-cycle qualifier; Addr_bus, R_nW and Data_bus_in are valid for exactly one CPU bus cycle.
- Addr_bus  in  16  CPU address.
- Data_bus_in  in  8  CPU write data.
- R_nW  in  1  1 = read, 0 = write.
- Data_bus_out  out  8  read data returned to the CPU.
- rd_hit  out  1  high for one cycle when Data_bus_out carries a valid controller read.
- pad_latch  out  1  controller parallel-load strobe; active high.
- pad_clk  out  2  per-port serial clock; idle high, pulses low; bit 0 = $4016, bit 1 = $4017.
- pad_data  in  2  per-port serial data; active low (0 = button pressed); asynchronous.

Behaviour:
- Reset values, applied immediately on rst high:
  - Data_bus_out = 8'h00, rd_hit = 0.
  - pad_latch = 0, pad_clk = 2'b11.
  - Pulse counters = 0, synchronisers = 2'b11.
- Synchronisation: pad_data passes through a 2-FF synchroniser per port; sync[n] is the second-stage output.
- Decode: hit0 = (Addr_bus == 16'h4016), hit1 = (Addr_bus == 16'h4017). Decode is qualified by bus_en.
- Write to $4016 (bus_en & ~R_nW & hit0):
  - strobe <= Data_bus_in[0].
  - pad_latch follows strobe one cycle after the write cycle.
  - Bits 7:1 are ignored.
- Write to $4017: ignored (the frame counter is owned elsewhere). Writes never assert rd_hit.
- Read of port n (bus_en & R_nW & hitn):
  - In the following cycle, Data_bus_out = {OPEN_BUS_HI, 4'b0000, ~sync[n]} and rd_hit = 1.
  - The data bit is captured in the read cycle, before any clock edge is issued to the pad.
- All other cycles: Data_bus_out = 8'h00 and rd_hit = 0. Latency is exactly 1 cycle, with no wait states.
- Per-port clock state machine, states IDLE and PULSE:
  - IDLE -> PULSE on a read of port n while strobe == 0. pad_clk[n] goes low in the same cycle rd_hit rises, and the counter loads CLK_PULSE.
  - PULSE: the counter decrements each cycle. At 1 -> 0, the state returns to IDLE and pad_clk[n] goes high. This rising edge shifts the pad.
  - A read of port n while strobe == 1 produces no pulse. The pad stays in parallel load and repeated reads return button A.
- Boundary conditions:
  - Re-read of the same port during PULSE: the counter reloads CLK_PULSE, pad_clk[n] stays low, and no extra edge is issued. Data is the current sync[n].
  - Write of strobe = 1 during PULSE: the pulse aborts and pad_clk goes to 2'b11 in the next cycle. The counter clears.
  - Write of strobe = 0 and a read in the same cycle cannot occur (one access per bus_en).
  - The counter width is sized for CLK_PULSE and never wraps.
  - Reads of port 0 and port 1 pulse independently.
  - Reset asserted mid-pulse: pad_clk = 2'b11 immediately, with no glitch after release.

Optional Feature:
- Macro: JOYPAD_DBG_EN.
- When defined, adds outputs pad0_dbg[7:0], pad1_dbg[7:0], rd_cnt0_dbg[2:0] and rd_cnt1_dbg[2:0]:
  - On each read of port n, pad_n_dbg <= {pad_n_dbg[6:0], ~sync[n]} and rd_cntn increments mod 8.
  - Writing strobe = 1 clears the counts.
  - Reset clears everything to 0.
- When not defined, none of these ports or registers exist, and there is no functional difference on the other ports.

Test Plan:
1. Assert rst mid-run with pad_clk[0] low -> all outputs at reset values in the same cycle: pad_clk = 2'b11, Data_bus_out = 8'h00, rd_hit = 0, pad_latch = 0.
2. Write 8'h01 then 8'h00 to $4016 -> pad_latch = 1 one cycle after the first write, and 0 one cycle after the second. A write of 8'hFF to $4017 changes nothing.
3. strobe = 0, pad_data = 2'b10, read $4016 -> next cycle Data_bus_out = 8'h41, rd_hit = 1. pad_clk[0] is low for exactly 4 cycles and pad_clk[1] stays 1.
4. Pad model preloaded with 8'hA5 (bit 0 first), strobe 1 then 0, then 8 reads of $4017 spaced 12 cycles apart -> returned bit 0 sequence is 1,0,1,0,0,1,0,1. Exactly 8 low pulses on pad_clk[1] and none on pad_clk[0].
5. strobe = 1, three reads of $4016 with the A bit pressed -> each returns 8'h41 and pad_clk stays 2'b11. Then write strobe = 1 during an active pulse (after reverting strobe) -> pad_clk high next cycle.
6. Reads of $4015 and $4018, and a read with bus_en = 0 at $4016 -> rd_hit = 0, Data_bus_out = 8'h00, no pulse. With JOYPAD_DBG_EN, test 4 ends with pad1_dbg = 8'hA5 (MSB = first bit) and rd_cnt1_dbg = 0.
